// File: rtl/seg7_scan_driver_if.sv
// Host-write and display-output bundle for the multiplexed 7-segment scanner.
// The host side (master) writes digit data; the scanner (slave) drives the display.
interface seg7_scan_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
) ();
  localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic                    load;
  logic [NUM_DIGITS-1:0]   an;
  logic [6:0]              seg;
  logic                    dp;
  logic [IDX_W-1:0]        digit_idx;
  logic                    frame_done;

  modport master (
    output value, dp_in, load,
    input  an, seg, dp, digit_idx, frame_done
  );

  modport slave (
    input  value, dp_in, load,
    output an, seg, dp, digit_idx, frame_done
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment scanner: advances one digit per rising scan_clk level,
// double-buffers host data so frames never tear, optional leading-zero blanking.
module seg7_scan_driver #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter bit          ACTIVE_LOW    = 1'b1,
  parameter bit          BLANK_LEADING = 1'b1
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               scan_clk,
  seg7_scan_driver_if.slave  bus
);
  localparam int unsigned      IDX_W = $clog2(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_DIGITS - 1);

  logic                    scan_q;
  logic                    adv;
  logic                    wrap;
  logic [IDX_W-1:0]        idx;
  logic [IDX_W-1:0]        idx_nxt;

  logic [4*NUM_DIGITS-1:0] pend;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic                    pend_vld;
  logic [4*NUM_DIGITS-1:0] act;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [4*NUM_DIGITS-1:0] act_nxt;
  logic [NUM_DIGITS-1:0]   act_dp_nxt;

  logic [NUM_DIGITS-1:0]   blank;
  logic [NUM_DIGITS-1:0]   an_hot;
  logic [3:0]              nib;
  logic                    dp_sel;
  logic                    blank_sel;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [6:0]              seg_nxt;
  logic                    dp_nxt;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign adv  = scan_clk & ~scan_q;
  assign wrap = adv && (idx >= LAST);

  always_comb begin
    idx_nxt = idx;
    if (adv) begin
      if (idx >= LAST) idx_nxt = '0;
      else             idx_nxt = idx + IDX_W'(1);
    end
  end

  // Outputs are registered on the advance edge, so decode from the buffer
  // contents that will be active after this edge, not the current ones.
  always_comb begin
    act_nxt    = act;
    act_dp_nxt = act_dp;
    if (wrap && pend_vld) begin
      act_nxt    = pend;
      act_dp_nxt = pend_dp;
    end
  end

  always_comb begin
    blank    = '0;
    zero_run = 1'b1;
    for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
      zero_run = zero_run && (act_nxt[4*(NUM_DIGITS-1-j) +: 4] == 4'h0);
      blank[NUM_DIGITS-1-j] = BLANK_LEADING && (j != NUM_DIGITS - 1) && zero_run;
    end
  end

  always_comb begin
    an_hot    = '0;
    nib       = 4'h0;
    dp_sel    = 1'b0;
    blank_sel = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      if (idx_nxt == IDX_W'(k)) begin
        an_hot[k] = 1'b1;
        nib       = act_nxt[4*k +: 4];
        dp_sel    = act_dp_nxt[k];
        blank_sel = blank[k];
      end
    end
  end

  always_comb begin
    an_nxt  = ACTIVE_LOW ? ~an_hot : an_hot;
    seg_nxt = blank_sel ? 7'h00 : hex7(nib);
    if (ACTIVE_LOW) seg_nxt = ~seg_nxt;
    dp_nxt  = ACTIVE_LOW ? ~dp_sel : dp_sel;
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      scan_q         <= 1'b0;
      idx            <= '0;
      pend           <= '0;
      pend_dp        <= '0;
      pend_vld       <= 1'b0;
      act            <= '0;
      act_dp         <= '0;
      bus.an         <= {NUM_DIGITS{ACTIVE_LOW}};
      bus.seg        <= {7{ACTIVE_LOW}};
      bus.dp         <= ACTIVE_LOW;
      bus.frame_done <= 1'b0;
    end else begin
      scan_q         <= scan_clk;
      idx            <= idx_nxt;
      bus.frame_done <= wrap;
      act            <= act_nxt;
      act_dp         <= act_dp_nxt;
      if (wrap) pend_vld <= 1'b0;
      // A load on the wrap edge lands in pending after the copy above, so it
      // shows from the following frame.
      if (bus.load) begin
        pend     <= bus.value;
        pend_dp  <= bus.dp_in;
        pend_vld <= 1'b1;
      end
      if (adv) begin
        bus.an  <= an_nxt;
        bus.seg <= seg_nxt;
        bus.dp  <= dp_nxt;
      end
    end
  end

  assign bus.digit_idx = idx;
endmodule
